// File: rtl/registros_param_if.sv
// Register bank bus: write port, pointer-update port, two read ports, R0 tap and wrap flag.
interface registros_param_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  logic [DATA_W-1:0] Mux_a_Reg;
  logic [SEL_W-1:0]  Sel_W;
  logic              Load_Store;
  logic [SEL_W-1:0]  Sel_RX;
  logic [SEL_W-1:0]  Sel_RY;
  logic              Inc_En;
  logic              Inc_Dec;
  logic [SEL_W-1:0]  Sel_Inc;
  logic [DATA_W-1:0] RX;
  logic [DATA_W-1:0] RY;
  logic [DATA_W-1:0] R0;
  logic              o_Wrap;

  modport master (
    output Mux_a_Reg, Sel_W, Load_Store, Sel_RX, Sel_RY, Inc_En, Inc_Dec, Sel_Inc,
    input  RX, RY, R0, o_Wrap
  );

  modport slave (
    input  Mux_a_Reg, Sel_W, Load_Store, Sel_RX, Sel_RY, Inc_En, Inc_Dec, Sel_Inc,
    output RX, RY, R0, o_Wrap
  );
endinterface

// File: rtl/registros_param.sv
// Parametrised register bank with pointer +/-1 port and wrap flag; REGISTROS_WRITE_BYPASS_EN forwards write data to reads.
// Writes/updates land on the next edge, reads are combinational; no backpressure, every request is taken.
module registros_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input logic              i_Clk,
  input logic              i_Reset,
  registros_param_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wrap_q;
  logic              wrap_d;

  logic              wr_hit;
  logic              inc_hit;
  logic [DATA_W-1:0] rx_st;
  logic [DATA_W-1:0] ry_st;
  logic [DATA_W-1:0] inc_cur;
  logic [DATA_W-1:0] inc_nxt;

  always_comb begin
    wr_hit  = bus.Load_Store && (32'(bus.Sel_W) < NUM_REGS);
    // A write to the same register takes priority and suppresses the pointer update.
    inc_hit = bus.Inc_En && (32'(bus.Sel_Inc) < NUM_REGS) &&
              !(wr_hit && (bus.Sel_Inc == bus.Sel_W));

    rx_st   = '0;
    ry_st   = '0;
    inc_cur = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.Sel_RX  == SEL_W'(k)) rx_st   = regs_q[k];
      if (bus.Sel_RY  == SEL_W'(k)) ry_st   = regs_q[k];
      if (bus.Sel_Inc == SEL_W'(k)) inc_cur = regs_q[k];
    end

    inc_nxt = bus.Inc_Dec ? (inc_cur - DATA_W'(1)) : (inc_cur + DATA_W'(1));

    regs_d = regs_q;
    wrap_d = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (inc_hit && (bus.Sel_Inc == SEL_W'(k))) regs_d[k] = inc_nxt;
      if (wr_hit  && (bus.Sel_W   == SEL_W'(k))) regs_d[k] = bus.Mux_a_Reg;
    end
    if (inc_hit) begin
      wrap_d = bus.Inc_Dec ? (inc_cur == '0) : (inc_cur == '1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef REGISTROS_WRITE_BYPASS_EN
  assign bus.RX = (wr_hit && (bus.Sel_RX == bus.Sel_W)) ? bus.Mux_a_Reg : rx_st;
  assign bus.RY = (wr_hit && (bus.Sel_RY == bus.Sel_W)) ? bus.Mux_a_Reg : ry_st;
  assign bus.R0 = (wr_hit && (bus.Sel_W == '0))        ? bus.Mux_a_Reg : regs_q[0];
`else
  assign bus.RX = rx_st;
  assign bus.RY = ry_st;
  assign bus.R0 = regs_q[0];
`endif

  assign bus.o_Wrap = wrap_q;

endmodule

// File: doc/registros_param.md
Name: registros_param

Overview:
- Parametrised successor to the MicroUAZ 8-entry register bank.
- Generalised in data width and register count; adds a dedicated write select, a pointer post-increment/decrement port with a registered wrap flag, and out-of-range select handling.
- Sits between the writeback mux and the ALU operand inputs.
- RX/RY feed the ALU; R0 is the accumulator tap.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 8, number of registers (2..256)
SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_REGS

Ports:
i_Clk  in  1  clock, rising edge
i_Reset  in  1  synchronous, active-high reset
Mux_a_Reg  in  DATA_W  write data from writeback mux
Sel_W  in  SEL_W  write register select
Load_Store  in  1  write enable
Sel_RX  in  SEL_W  read port X select
Sel_RY  in  SEL_W  read port Y select
Inc_En  in  1  pointer update enable
Inc_Dec  in  1  0 = +1, 1 = -1
Sel_Inc  in  SEL_W  pointer register select
RX  out  DATA_W  read port X data
RY  out  DATA_W  read port Y data
R0  out  DATA_W  continuous copy of register 0
o_Wrap  out  1  registered pulse: last pointer update wrapped

Behaviour:
- Reset: synchronous, active-high.
  - On the edge with i_Reset=1, all registers and o_Wrap clear to 0.
  - Reset overrides Load_Store and Inc_En on that edge.
  - RX, RY and R0 read 0 on the cycle after the reset edge.
- Write:
  - When Load_Store=1 and Sel_W<NUM_REGS, reg[Sel_W] <= Mux_a_Reg at the rising edge.
  - Latency: 1 edge.
- Read:
  - RX = reg[Sel_RX] and RY = reg[Sel_RY], combinational from current state.
  - Both ports may select the same register.
- Out-of-range selects (>= NUM_REGS):
  - Reads return 0.
  - Writes and pointer updates are ignored.
  - o_Wrap stays 0.
- Pointer update:
  - When Inc_En=1 and Sel_Inc<NUM_REGS: reg[Sel_Inc] <= reg[Sel_Inc] +1 or -1, modulo 2**DATA_W.
  - o_Wrap <= 1 for exactly one cycle if the update wrapped (all-ones to 0 on increment, 0 to all-ones on decrement); otherwise o_Wrap <= 0.
- Simultaneous write and pointer update:
  - Sel_W == Sel_Inc: the write wins, the update is dropped, o_Wrap <= 0.
  - Different registers: both take effect on the same edge.
- Reset mid-sequence: any pending update is discarded; there is no partial state.
- Width rule: Mux_a_Reg is stored unmodified; pointer arithmetic is done at DATA_W bits, with no carry out beyond o_Wrap.

Optional Feature:
- Macro REGISTROS_WRITE_BYPASS_EN.
- Defined:
  - When Load_Store=1 and Sel_RX==Sel_W (in range), RX shows Mux_a_Reg in the same cycle. RY and R0 behave likewise.
  - Bypass applies to write data only, never to pointer updates.
- Undefined: reads always return stored state; a read of the register being written returns the old value until after the edge.

Test Plan:
1. Reset, then write reg k = k+2 for k=0..7 (Sel_W=k, Load_Store=1), then sweep Sel_RX=3 and Sel_RY=7 -> RX=0x05, RY=0x09, R0=0x02.
2. Write reg2=0xFE, then Inc_En=1, Inc_Dec=0, Sel_Inc=2 for 2 cycles -> reg2 = 0xFF then 0x00; o_Wrap=0 then 1 (one cycle), then 0.
3. reg4=0x00, Inc_Dec=1, Sel_Inc=4 -> reg4=0xFF, o_Wrap pulses 1. Same cycle, Load_Store=1, Sel_W=1, data 0x33 -> reg1=0x33.
4. Load_Store=1, Sel_W=5, Mux_a_Reg=0xAA together with Inc_En=1, Sel_Inc=5 -> reg5=0xAA, o_Wrap=0.
5. Sel_RX=Sel_W=6, Load_Store=1, Mux_a_Reg=0x5C:
   - Before the edge: RX=0x5C with REGISTROS_WRITE_BYPASS_EN defined, old value without it.
   - After the edge: RX=0x5C in both builds.
6. NUM_REGS=6, SEL_W=3:
   - Write Sel_W=7 -> no state change; Sel_RX=7 -> RX=0.
   - Assert i_Reset together with Load_Store=1 -> all registers 0; write ignored.
